// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the intersection controller slice:
//   - timer_state_t : phase_timer state encoding (IDLE / RUN / DONE)
//   - TIME_W        : width of the phase duration / seconds counter
//   - DEFAULT_CLK_DIV : system clock cycles per second on the target board
//   - light_t       : signal-head light codes used by trafficFSM
// -----------------------------------------------------------------------------
package traffic_pkg;

    localparam int unsigned TIME_W          = 7;
    localparam int unsigned DEFAULT_CLK_DIV = 50000000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_t;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        YELLOW = 2'd1,
        GREEN  = 2'd2
    } light_t;

endpackage : traffic_pkg

// File: rtl/tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Modulo-CLK_DIV cycle counter producing the 1 s boundary for phase_timer.
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-low reset (counter -> 0)
//   enable : count while high; counter holds while low
//   clear  : synchronous clear to 0, overrides enable
//   wrap   : high in the cycle where the counter sits at CLK_DIV-1 and is
//            enabled, i.e. the cycle whose closing edge completes a second
// -----------------------------------------------------------------------------
module tick_prescaler #(
    parameter int unsigned CLK_DIV = traffic_pkg::DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic wrap
);

    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] r_count;
    logic          w_at_last;

    assign w_at_last = (r_count == LAST);
    assign wrap      = enable && w_at_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= w_at_last ? '0 : r_count + 1'b1;
        end
    end

endmodule : tick_prescaler

// File: rtl/phase_timer.sv
// -----------------------------------------------------------------------------
// phase_timer
// Phase-duration timer serving the traffic controller's timer handshake.
// The controller loads a duration in whole seconds; the block counts it down
// on a 1 s boundary derived from clk and then holds expired high.
// Ports:
//   clk           : system clock, rising edge
//   reset         : asynchronous, active-low reset
//   startTimer    : load request, sampled every rising edge
//   timeParameter : duration in seconds (unsigned), sampled when startTimer=1
//   expired       : level, high whenever no countdown is in progress
//   secondsLeft   : remaining whole seconds
//   tick          : one-cycle strobe on each 1 s boundary while running
// All outputs are registered.
// -----------------------------------------------------------------------------
module phase_timer #(
    parameter int unsigned CLK_DIV = traffic_pkg::DEFAULT_CLK_DIV,
    parameter int unsigned TIME_W  = traffic_pkg::TIME_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              startTimer,
    input  logic [TIME_W-1:0] timeParameter,
    output logic              expired,
    output logic [TIME_W-1:0] secondsLeft,
    output logic              tick
);

    import traffic_pkg::*;

    timer_state_t      r_state;
    timer_state_t      w_state_nxt;
    logic [TIME_W-1:0] r_secs;
    logic [TIME_W-1:0] w_secs_nxt;
    logic              r_tick;
    logic              w_tick_nxt;
    logic              r_expired;
    logic              w_expired_nxt;

    logic              w_run;
    logic              w_wrap;

    assign w_run = (r_state == RUN);

    // A load clears the prescaler in every state, so a restart or a
    // start/wrap collision always begins a fresh full second.
    tick_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .enable (w_run),
        .clear  (startTimer),
        .wrap   (w_wrap)
    );

    // ------------------------------------------------------------------
    // State / output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_secs    <= '0;
            r_tick    <= 1'b0;
            r_expired <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_secs    <= w_secs_nxt;
            r_tick    <= w_tick_nxt;
            r_expired <= w_expired_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_secs_nxt    = r_secs;
        w_tick_nxt    = 1'b0;
        w_expired_nxt = r_expired;

        if (startTimer) begin
            // Load has priority over the prescaler wrap: the aborted second
            // produces no tick and cannot expire the counter.
            if (timeParameter != '0) begin
                w_state_nxt   = RUN;
                w_secs_nxt    = timeParameter;
                w_expired_nxt = 1'b0;
            end else begin
                w_state_nxt   = DONE;
                w_secs_nxt    = '0;
                w_expired_nxt = 1'b1;
            end
        end else begin
            unique case (r_state)
                RUN: begin
                    w_expired_nxt = 1'b0;
                    if (w_wrap) begin
                        w_tick_nxt = 1'b1;
                        // RUN always holds a non-zero count; the guard keeps
                        // the counter from ever wrapping below zero.
                        if (r_secs <= TIME_W'(1)) begin
                            w_secs_nxt    = '0;
                            w_state_nxt   = DONE;
                            w_expired_nxt = 1'b1;
                        end else begin
                            w_secs_nxt = r_secs - 1'b1;
                        end
                    end
                end
                IDLE, DONE: begin
                    w_expired_nxt = 1'b1;
                end
                default: begin
                    w_state_nxt   = IDLE;
                    w_secs_nxt    = '0;
                    w_expired_nxt = 1'b1;
                end
            endcase
        end
    end

    assign expired     = r_expired;
    assign secondsLeft = r_secs;
    assign tick        = r_tick;

endmodule : phase_timer

// File: tb/tb_phase_timer.sv
// -----------------------------------------------------------------------------
// tb_phase_timer
// Directed bench for phase_timer with CLK_DIV=4. Each scenario pushes the
// tick / expiry events it expects (edge number + secondsLeft) into a queue;
// a negedge monitor pops and compares an entry whenever the DUT strobes tick
// or raises expired. Direct checks cover levels between events.
// -----------------------------------------------------------------------------
module tb_phase_timer;

    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned TW      = 7;
    localparam int EV_TICK = 0;
    localparam int EV_EXP  = 1;

    typedef struct {
        int kind;
        int cyc;
        int secs;
    } ev_t;

    logic          clk;
    logic          reset;
    logic          startTimer;
    logic [TW-1:0] timeParameter;
    logic          expired;
    logic [TW-1:0] secondsLeft;
    logic          tick;

    int   cyc;
    int   checks;
    int   failures;
    ev_t  sb[$];
    logic prev_exp;

    phase_timer #(
        .CLK_DIV (CLK_DIV),
        .TIME_W  (TW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .startTimer    (startTimer),
        .timeParameter (timeParameter),
        .expired       (expired),
        .secondsLeft   (secondsLeft),
        .tick          (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: after posedge number n, cyc == n.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int c, input int s);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.secs = s;
        sb.push_back(e);
    endtask

    task automatic pop_check(input int kind, input string name);
        ev_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s unexpected event actual_cycle=%0d secs=%0d required=none", name, cyc, secondsLeft);
        end else begin
            e = sb.pop_front();
            chk({name, "_kind"}, kind, e.kind);
            chk({name, "_cycle"}, cyc, e.cyc);
            chk({name, "_secs"}, int'(secondsLeft), e.secs);
        end
    endtask

    // Monitor: every tick strobe and every rising edge of expired is an
    // output event that must match the head of the scoreboard.
    initial prev_exp = 1'b1;
    always @(negedge clk) begin
        if (reset) begin
            if (tick) pop_check(EV_TICK, "tick_event");
            if (expired && !prev_exp) pop_check(EV_EXP, "expired_event");
        end
        prev_exp = expired;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) next_cycle();
    endtask

    task automatic start(input int n, output int k);
        startTimer    = 1'b1;
        timeParameter = TW'(n);
        next_cycle();
        startTimer    = 1'b0;
        k             = cyc;
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, "_expired"}, int'(expired), 1);
        chk({name, "_secs"}, int'(secondsLeft), 0);
        chk({name, "_tick"}, int'(tick), 0);
    endtask

    task automatic chk_sb_empty(input string name);
        chk({name, "_pending_events"}, sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        int k;
        int k2;
        checks        = 0;
        failures      = 0;
        startTimer    = 1'b0;
        timeParameter = '0;
        reset         = 1'b1;
        #2 reset      = 1'b0;
        #1;
        chk_idle_outputs("reset_async");
        next_cycle();
        next_cycle();
        #1 reset = 1'b1;

        // Reset release, no start: idle outputs for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            next_cycle();
            chk_idle_outputs("post_reset");
        end
        chk_sb_empty("post_reset");

        // Basic count, N=3.
        start(3, k);
        chk("basic_expired_k", int'(expired), 0);
        chk("basic_secs_k", int'(secondsLeft), 3);
        push(EV_TICK, k + 4, 2);
        push(EV_TICK, k + 8, 1);
        push(EV_TICK, k + 12, 0);
        push(EV_EXP,  k + 12, 0);
        wait_until(k + 11);
        chk("basic_expired_k11", int'(expired), 0);
        chk("basic_secs_k11", int'(secondsLeft), 1);
        wait_until(k + 12);
        chk("basic_expired_k12", int'(expired), 1);
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            chk_idle_outputs("basic_hold");
        end
        chk_sb_empty("basic");

        // startTimer held high: frozen at N, no tick.
        startTimer    = 1'b1;
        timeParameter = TW'(3);
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            chk("held_secs", int'(secondsLeft), 3);
            chk("held_expired", int'(expired), 0);
            chk("held_tick", int'(tick), 0);
        end
        startTimer = 1'b0;
        k = cyc;
        push(EV_TICK, k + 4, 2);
        push(EV_TICK, k + 8, 1);
        push(EV_TICK, k + 12, 0);
        push(EV_EXP,  k + 12, 0);
        wait_until(k + 14);
        chk_sb_empty("held");

        // Zero load from DONE: expired never drops.
        start(0, k);
        for (int i = 0; i < 12; i++) begin
            chk_idle_outputs("zero_done");
            next_cycle();
        end
        chk_sb_empty("zero_done");

        // Zero load while running: expired returns to 1 on the load edge.
        start(3, k);
        wait_until(k + 2);
        start(0, k2);
        push(EV_EXP, k2, 0);
        chk_idle_outputs("zero_run");
        wait_until(k2 + 8);
        chk_idle_outputs("zero_run_late");
        chk_sb_empty("zero_run");

        // Restart while running: N=5 then N=2 sampled at k+6.
        start(5, k);
        push(EV_TICK, k + 4, 4);
        wait_until(k + 5);
        start(2, k2);
        chk("restart_secs", int'(secondsLeft), 2);
        chk("restart_expired", int'(expired), 0);
        push(EV_TICK, k2 + 4, 1);
        push(EV_TICK, k2 + 8, 0);
        push(EV_EXP,  k2 + 8, 0);
        wait_until(k2 + 10);
        chk_sb_empty("restart");

        // Collision: reload with N=1 on the first wrap edge.
        start(2, k);
        wait_until(k + 3);
        start(1, k2);
        chk("collide_tick", int'(tick), 0);
        chk("collide_secs", int'(secondsLeft), 1);
        chk("collide_expired", int'(expired), 0);
        push(EV_TICK, k2 + 4, 0);
        push(EV_EXP,  k2 + 4, 0);
        wait_until(k2 + 3);
        chk("collide_expired_k3", int'(expired), 0);
        wait_until(k2 + 6);
        chk_sb_empty("collide");

        // Async reset mid-count after two ticks.
        start(10, k);
        push(EV_TICK, k + 4, 9);
        push(EV_TICK, k + 8, 8);
        wait_until(k + 9);
        chk("midreset_secs_before", int'(secondsLeft), 8);
        #2 reset = 1'b0;
        #1;
        chk_idle_outputs("midreset_async");
        next_cycle();
        next_cycle();
        #2 reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            next_cycle();
            chk_idle_outputs("midreset_after");
        end
        chk_sb_empty("midreset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_phase_timer
